// File: rtl/cpu_branch_predictor_pkg.sv
// Shared types and encodings for the branch history table: 2-bit counter values
// and the predictor's sweep/run state.
package cpu_branch_predictor_pkg;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t BHT_STRONG_NT = 2'b00;
  localparam bht_ctr_t BHT_WEAK_NT   = 2'b01;
  localparam bht_ctr_t BHT_WEAK_T    = 2'b10;
  localparam bht_ctr_t BHT_STRONG_T  = 2'b11;
  localparam bht_ctr_t BHT_INIT      = BHT_WEAK_NT;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bp_state_e;

endpackage

// File: rtl/cpu_branch_counter_update.sv
// Saturating 2-bit counter step: move toward strong-taken on a taken outcome,
// toward strong-not-taken otherwise.
module cpu_branch_counter_update
  import cpu_branch_predictor_pkg::*;
(
  input  bht_ctr_t ctr_i,
  input  logic     taken_i,
  output bht_ctr_t ctr_o
);

  // NOTE: assigning a default first in always_comb keeps every path driven, so no latch is inferred.
  always_comb begin
    ctr_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != BHT_STRONG_T) ctr_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != BHT_STRONG_NT) ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/cpu_branch_predictor.sv
// Direct-mapped BHT of 2-bit saturating counters with a post-reset init sweep,
// registered misprediction pulse and wrapping branch/misprediction statistics.
module cpu_branch_predictor
  import cpu_branch_predictor_pkg::*;
#(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ready,
  input  logic [31:0] pred_pc,
  output logic        pred_taken,
  input  logic        res_valid,
  input  logic [31:0] res_pc,
  input  logic        res_predicted_taken,
  input  logic        res_condition,
  output logic        mispredict,
  output logic        mispredict_taken,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  bp_state_e             state_q, state_d;
  logic [INDEX_BITS-1:0] sweep_q, sweep_d;
  bht_ctr_t              bht_q [ENTRIES];

  logic        mispredict_q, mispredict_d;
  logic        mispredict_taken_q, mispredict_taken_d;
  logic [31:0] branch_count_q, branch_count_d;
  logic [31:0] mispredict_count_q, mispredict_count_d;

  logic [INDEX_BITS-1:0] pred_idx, res_idx;
  logic                  run_update;
  bht_ctr_t              ctr_next;
  logic                  unused_pc_bits;

  assign pred_idx       = pred_pc[INDEX_BITS+1:2];
  assign res_idx        = res_pc[INDEX_BITS+1:2];
  assign unused_pc_bits = ^{pred_pc[31:INDEX_BITS+2], pred_pc[1:0],
                            res_pc[31:INDEX_BITS+2], res_pc[1:0]};

  assign run_update = (state_q == ST_RUN) && res_valid;

  cpu_branch_counter_update u_update (
    .ctr_i   (bht_q[res_idx]),
    .taken_i (res_condition),
    .ctr_o   (ctr_next)
  );

  // Sweep one entry per cycle; the pointer wraps back to 0 as RUN is entered.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    case (state_q)
      ST_INIT: begin
        sweep_d = sweep_q + 1'b1;
        if (&sweep_q) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // NOTE: the table has no reset branch; the INIT sweep initialises it, keeping it a plain register array.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_INIT) bht_q[sweep_q] <= BHT_INIT;
      else if (run_update)    bht_q[res_idx] <= ctr_next;
    end
  end

  always_comb begin
    mispredict_d       = 1'b0;
    mispredict_taken_d = mispredict_taken_q;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (run_update) begin
      branch_count_d = branch_count_q + 32'd1;
      if (res_predicted_taken != res_condition) begin
        mispredict_d       = 1'b1;
        mispredict_taken_d = res_condition;
        mispredict_count_d = mispredict_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mispredict_q       <= 1'b0;
      mispredict_taken_q <= 1'b0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      mispredict_q       <= mispredict_d;
      mispredict_taken_q <= mispredict_taken_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign ready            = (state_q == ST_RUN);
  assign pred_taken       = ready & bht_q[pred_idx][1];
  assign mispredict       = mispredict_q;
  assign mispredict_taken = mispredict_taken_q;
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_cpu_branch_predictor.sv
// Self-checking bench for cpu_branch_predictor: integer-array reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_cpu_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic        res_valid;
  logic [31:0] res_pc;
  logic        res_predicted_taken;
  logic        res_condition;
  logic        mispredict;
  logic        mispredict_taken;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  always #5 clk = ~clk;

  cpu_branch_predictor #(.INDEX_BITS(6)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .ready               (ready),
    .pred_pc             (pred_pc),
    .pred_taken          (pred_taken),
    .res_valid           (res_valid),
    .res_pc              (res_pc),
    .res_predicted_taken (res_predicted_taken),
    .res_condition       (res_condition),
    .mispredict          (mispredict),
    .mispredict_taken    (mispredict_taken),
    .branch_count        (branch_count),
    .mispredict_count    (mispredict_count)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: counters as plain integers 0..3, saturated with min/max.
  int          m_ctr [64];
  int          m_init;
  bit          m_ready;
  bit          m_mp, m_mt;
  logic [31:0] m_bc, m_mc;
  int          preload_seq  = 0;
  int          preload_seen = 0;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    int ri;
    if (preload_seq != preload_seen) begin
      m_bc = 32'hFFFF_FFFF;
      preload_seen = preload_seq;
    end
    if (rst) begin
      m_init = 0; m_ready = 0; m_mp = 0; m_mt = 0; m_bc = 0; m_mc = 0;
    end else if (!m_ready) begin
      m_ctr[m_init] = 1;
      m_init++;
      if (m_init == 64) m_ready = 1;
      m_mp = 0;
    end else begin
      m_mp = 0;
      if (res_valid) begin
        ri = int'((res_pc >> 2) % 64);
        m_ctr[ri] = res_condition ? ((m_ctr[ri] < 3) ? m_ctr[ri] + 1 : 3)
                                  : ((m_ctr[ri] > 0) ? m_ctr[ri] - 1 : 0);
        m_bc = m_bc + 32'd1;
        if (res_predicted_taken != res_condition) begin
          m_mp = 1; m_mt = res_condition; m_mc = m_mc + 32'd1;
        end
      end
    end
  end

  always @(negedge clk) begin
    int  pi;
    bit  exp_pred;
    if (chk_en) begin
      pi = int'((pred_pc >> 2) % 64);
      exp_pred = m_ready && (m_ctr[pi] >= 2);
      check("model_ready",            {31'd0, ready},            {31'd0, m_ready});
      check("model_pred_taken",       {31'd0, pred_taken},       {31'd0, exp_pred});
      check("model_mispredict",       {31'd0, mispredict},       {31'd0, m_mp});
      check("model_mispredict_taken", {31'd0, mispredict_taken}, {31'd0, m_mt});
      check("model_branch_count",     branch_count,              m_bc);
      check("model_mispredict_count", mispredict_count,          m_mc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic pt, input logic cond);
    res_valid = 1'b1; res_pc = pc; res_predicted_taken = pt; res_condition = cond;
  endtask

  task automatic sweep_and_check_ready(input string tag);
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (i == 63) check({tag, "_ready_low_63"}, {31'd0, ready}, 32'd0);
      if (i == 64) check({tag, "_ready_high_64"}, {31'd0, ready}, 32'd1);
    end
  endtask

  initial begin
    logic [2:0] exp_taken_pred;
    rst = 1'b1; pred_pc = '0; res_valid = 1'b0; res_pc = '0;
    res_predicted_taken = 1'b0; res_condition = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_bc", branch_count, 32'd0);
    rst = 1'b0;

    // INIT sweep with a resolution that must be ignored.
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (i == 3) resolve(32'h100, 1'b0, 1'b1);
      if (i == 4) res_valid = 1'b0;
      if (i == 5) begin
        check("init_no_mispredict", {31'd0, mispredict}, 32'd0);
        check("init_bc_zero", branch_count, 32'd0);
      end
      if (i == 63) check("ready_low_63", {31'd0, ready}, 32'd0);
      if (i == 64) check("ready_high_64", {31'd0, ready}, 32'd1);
    end
    pred_pc = 32'h100; #1;
    check("pred_0x100_weak_nt", {31'd0, pred_taken}, 32'd0);

    // Three taken resolutions of 0x40.
    exp_taken_pred = 3'b110;
    pred_pc = 32'h40;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("pred_0x40_taken_seq", {31'd0, pred_taken}, {31'd0, exp_taken_pred[i]});
      resolve(32'h40, exp_taken_pred[i], 1'b1);
      tick();
      if (i == 0) begin
        check("first_taken_mispredict", {31'd0, mispredict}, 32'd1);
        check("first_taken_mp_taken", {31'd0, mispredict_taken}, 32'd1);
      end
    end
    res_valid = 1'b0; #1;
    check("pred_0x40_strong_t", {31'd0, pred_taken}, 32'd1);
    check("bc_after_taken", branch_count, 32'd3);
    check("mc_after_taken", mispredict_count, 32'd1);

    // Two not-taken from strong-T, observed through alias 0x140.
    pred_pc = 32'h140;
    for (int i = 0; i < 2; i++) begin
      resolve(32'h40, 1'b1, 1'b0);
      tick();
      check("nt_back_to_back_pulse", {31'd0, mispredict}, 32'd1);
      check("nt_mp_taken", {31'd0, mispredict_taken}, 32'd0);
      #1;
      check("alias_0x140_pred", {31'd0, pred_taken}, (i == 0) ? 32'd1 : 32'd0);
    end
    res_valid = 1'b0;
    check("bc_after_nt", branch_count, 32'd5);
    check("mc_after_nt", mispredict_count, 32'd3);

    // Same-cycle read and write of 0x80.
    pred_pc = 32'h80;
    resolve(32'h80, 1'b0, 1'b1);
    #1;
    check("same_cycle_old_value", {31'd0, pred_taken}, 32'd0);
    tick();
    res_valid = 1'b0; #1;
    check("same_cycle_new_value", {31'd0, pred_taken}, 32'd1);
    check("bc_after_same", branch_count, 32'd6);
    check("mc_after_same", mispredict_count, 32'd4);

    // Preload branch_count to all-ones and wrap it.
    @(negedge clk);
    #1;
    force dut.branch_count_q = 32'hFFFF_FFFF;
    preload_seq++;
    #1;
    release dut.branch_count_q;
    check("preload_bc", branch_count, 32'hFFFF_FFFF);
    resolve(32'h200, 1'b0, 1'b0);
    tick();
    res_valid = 1'b0;
    check("bc_wrap_to_zero", branch_count, 32'd0);

    // Mispredict, then reset mid-RUN drops the pulse and restarts the sweep.
    resolve(32'h80, 1'b0, 1'b1);
    tick();
    check("pre_reset_mispredict", {31'd0, mispredict}, 32'd1);
    res_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    check("rst_mispredict", {31'd0, mispredict}, 32'd0);
    check("rst_mp_taken", {31'd0, mispredict_taken}, 32'd0);
    check("rst_bc", branch_count, 32'd0);
    check("rst_mc", mispredict_count, 32'd0);
    rst = 1'b0;
    sweep_and_check_ready("reinit");
    #1;
    check("reinit_0x80_weak_nt", {31'd0, pred_taken}, 32'd0);
    tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
